// File: rtl/id_inst_queue.sv
// id_inst_queue: in-order {pc, inst} queue between the fetch path and decode.
// A circular buffer of DEPTH entries. Decode sees the head entry combinationally.
// A branch flush empties the queue, and a sticky flag records any fetch dropped while full.
// Optional macro ID_INST_QUEUE_BYPASS_EN: when the queue is empty, an incoming
// fetch is presented to decode in the same cycle. If decode consumes it in that
// cycle, it is not stored.
module id_inst_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_WD   = 32,
    parameter int INST_WD = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [PC_WD-1:0]         enq_pc,
    input  logic [INST_WD-1:0]       enq_inst,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [PC_WD-1:0]         deq_pc,
    output logic [INST_WD-1:0]       deq_inst,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_WD = $clog2(DEPTH);
    localparam int CNT_WD = PTR_WD + 1;

    logic [PC_WD-1:0]   pc_mem   [DEPTH];
    logic [INST_WD-1:0] inst_mem [DEPTH];
    logic [PTR_WD-1:0]  rd_ptr;
    logic [PTR_WD-1:0]  wr_ptr;

    logic head_valid;
    logic byp;
    logic enq_fire;
    logic enq_store;
    logic deq_pop;

    assign head_valid = (count != '0);
    // Full blocks enqueue even if the head is popped in the same cycle.
    assign enq_ready  = (count != CNT_WD'(DEPTH));
    assign enq_fire   = enq_valid & enq_ready & ~flush;

`ifdef ID_INST_QUEUE_BYPASS_EN
    assign byp = ~head_valid & enq_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    // A bypassed pair that is consumed immediately never occupies a slot.
    assign enq_store = enq_fire & ~(byp & deq_ready);
    assign deq_pop   = head_valid & deq_ready & ~flush;

    // Head presentation: stored entry first, then bypass, otherwise zero (NOP).
    always_comb begin
        deq_valid = 1'b0;
        deq_pc    = '0;
        deq_inst  = '0;
        if (!flush) begin
            if (head_valid) begin
                deq_valid = 1'b1;
                deq_pc    = pc_mem[rd_ptr];
                deq_inst  = inst_mem[rd_ptr];
            end else if (byp) begin
                deq_valid = 1'b1;
                deq_pc    = enq_pc;
                deq_inst  = enq_inst;
            end
        end
    end

    // Storage write. This storage has no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (enq_store) begin
            pc_mem[wr_ptr]   <= enq_pc;
            inst_mem[wr_ptr] <= enq_inst;
        end
    end

    // Pointer and occupancy update. Flush wins over any enqueue or dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_store) wr_ptr <= wr_ptr + PTR_WD'(1);
            if (deq_pop)   rd_ptr <= rd_ptr + PTR_WD'(1);
            case ({enq_store, deq_pop})
                2'b10:   count <= count + CNT_WD'(1);
                2'b01:   count <= count - CNT_WD'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag. Only reset clears it; flush does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        overflow <= 1'b0;
        else if (enq_valid && !enq_ready) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed self-checking bench for id_inst_queue (DEPTH=4, 32-bit pc/inst).
// Expectations follow the ID_INST_QUEUE_BYPASS_EN setting of the build.
module tb_id_inst_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_inst;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic        deq_ready;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    id_inst_queue #(.DEPTH(4), .PC_WD(32), .INST_WD(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_inst  (enq_inst),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_inst  (deq_inst),
        .deq_ready (deq_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    initial begin
        rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_pc = '0; enq_inst = '0; deq_ready = 1'b0;
        #1;
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_deq_pc",    deq_pc,         32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        step(); step();
        rst = 1'b1;

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'hBFC0_0000 + 32'(4 * i);
            enq_inst  = 32'h3C08_BFC0 + 32'(i);
            step();
        end
        enq_valid = 1'b0;
        #1;
        chk("full_count",     32'(count),     32'd4);
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        chk("full_head_pc",   deq_pc,         32'hBFC0_0000);

        // Enqueue attempt while full is dropped and flagged, even with a pop in the same cycle
        enq_valid = 1'b1; enq_pc = 32'hBFC0_0010; enq_inst = 32'hDEAD_BEEF; deq_ready = 1'b1;
        #1;
        chk("full_nopass_ready", 32'(enq_ready), 32'd0);
        chk("full_nopass_pc",    deq_pc,         32'hBFC0_0000);
        step();
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(count),    32'd3);
        chk("ovf_head",  deq_pc,        32'hBFC0_0004);

        // Drain the remaining three in order
        deq_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("drain_valid", 32'(deq_valid), 32'd1);
            chk("drain_pc",    deq_pc,         32'hBFC0_0000 + 32'(4 * i));
            chk("drain_inst",  deq_inst,       32'h3C08_BFC0 + 32'(i));
            step();
            chk("drain_count", 32'(count),     32'(3 - i));
        end
        #1;
        chk("empty_valid", 32'(deq_valid), 32'd0);
        chk("empty_pc",    deq_pc,         32'd0);
        chk("empty_inst",  deq_inst,       32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ovf_after_flush", 32'(overflow), 32'd1);

        // Two pre-loaded entries, then ten back-to-back enq+deq that wrap the pointers
        deq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h1000 + 32'(4 * i);
            enq_inst  = inst_of(enq_pc);
            step();
        end
        chk("conc_pre_count", 32'(count), 32'd2);
        deq_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h1008 + 32'(4 * k);
            enq_inst  = inst_of(enq_pc);
            #1;
            chk("conc_pc",   deq_pc,   32'h1000 + 32'(4 * k));
            chk("conc_inst", deq_inst, inst_of(32'h1000 + 32'(4 * k)));
            step();
            chk("conc_count", 32'(count), 32'd2);
        end
        enq_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            #1;
            chk("conc_tail_pc", deq_pc, 32'h1000 + 32'(4 * k));
            step();
        end
        chk("conc_end_count", 32'(count), 32'd0);

        // Flush with three stored entries and a concurrent enqueue
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h300 + 32'(4 * i);
            enq_inst  = inst_of(enq_pc);
            step();
        end
        chk("fl_pre_count", 32'(count), 32'd3);
        flush = 1'b1; enq_valid = 1'b1; enq_pc = 32'h200; enq_inst = inst_of(32'h200); deq_ready = 1'b1;
        #1;
        chk("fl_same_valid", 32'(deq_valid), 32'd0);
        chk("fl_same_pc",    deq_pc,         32'd0);
        step();
        flush = 1'b0; enq_valid = 1'b0;
        #1;
        chk("fl_next_count", 32'(count),     32'd0);
        chk("fl_next_valid", 32'(deq_valid), 32'd0);
        step();
        chk("fl_never_deq",  32'(deq_valid), 32'd0);

        // Empty queue with a fetch arriving while decode is ready
        enq_valid = 1'b1; enq_pc = 32'h100; enq_inst = 32'h2400_0100; deq_ready = 1'b1;
        #1;
`ifdef ID_INST_QUEUE_BYPASS_EN
        chk("byp_valid", 32'(deq_valid), 32'd1);
        chk("byp_pc",    deq_pc,         32'h100);
        chk("byp_inst",  deq_inst,       32'h2400_0100);
        step();
        enq_valid = 1'b0;
        #1;
        chk("byp_count", 32'(count),     32'd0);
        chk("byp_after", 32'(deq_valid), 32'd0);
`else
        chk("nobyp_valid0", 32'(deq_valid), 32'd0);
        step();
        enq_valid = 1'b0;
        #1;
        chk("nobyp_count1", 32'(count),     32'd1);
        chk("nobyp_valid1", 32'(deq_valid), 32'd1);
        chk("nobyp_pc",     deq_pc,         32'h100);
        chk("nobyp_inst",   deq_inst,       32'h2400_0100);
        step();
        chk("nobyp_count0", 32'(count),     32'd0);
`endif

        // Asynchronous reset in the middle of traffic with three entries stored
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h400 + 32'(4 * i);
            enq_inst  = inst_of(enq_pc);
            step();
        end
        chk("ar_pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_deq_valid", 32'(deq_valid), 32'd0);
        chk("ar_count",     32'(count),     32'd0);
        chk("ar_enq_ready", 32'(enq_ready), 32'd1);
        chk("ar_deq_inst",  deq_inst,       32'd0);
        chk("ar_overflow",  32'(overflow),  32'd0);
        enq_valid = 1'b0;
        step();
        rst = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
